// File: rtl/alu_exec_unit_if.sv
// Request/result bundle between the register-read stage, the execute ALU and its consumer.
// The master drives operations in; the slave (the ALU) returns registered results.
interface alu_exec_unit_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         alu_control;
    logic [WIDTH-1:0]   operand_a;
    logic [WIDTH-1:0]   operand_b;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   result;
    logic               zero;
    logic               result_valid;

    modport master (
        output in_valid, alu_control, operand_a, operand_b, shamt,
        input  in_ready, result, zero, result_valid
    );

    modport slave (
        input  in_valid, alu_control, operand_a, operand_b, shamt,
        output in_ready, result, zero, result_valid
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered single-cycle ops plus an iterative radix-2 shift-add MUL
// that holds in_ready low for WIDTH cycles while it runs.
module alu_exec_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input logic            clk,
    input logic            rst,
    alu_exec_unit_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StMul} state_e;

    localparam logic [3:0]       OpAnd = 4'd0;
    localparam logic [3:0]       OpOr  = 4'd1;
    localparam logic [3:0]       OpAdd = 4'd2;
    localparam logic [3:0]       OpSll = 4'd3;
    localparam logic [3:0]       OpSrl = 4'd4;
    localparam logic [3:0]       OpSub = 4'd5;
    localparam logic [3:0]       OpMul = 4'd6;
    localparam logic [3:0]       OpSlt = 4'd7;
    localparam logic [3:0]       OpNor = 4'd12;
    localparam logic [SHAMT_W:0] CountInit = (SHAMT_W + 1)'(WIDTH);
    localparam logic [SHAMT_W:0] CountOne  = (SHAMT_W + 1)'(1);

    state_e             state_q, state_d;
    logic [SHAMT_W:0]   count_q, count_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   alu_out;
    logic [WIDTH-1:0]   acc_sum;

    always_comb begin
        alu_out = '0;
        case (bus.alu_control)
            OpAnd:   alu_out = bus.operand_a & bus.operand_b;
            OpOr:    alu_out = bus.operand_a | bus.operand_b;
            OpAdd:   alu_out = bus.operand_a + bus.operand_b;
            OpSll:   alu_out = bus.operand_b << bus.shamt;
            OpSrl:   alu_out = bus.operand_b >> bus.shamt;
            OpSub:   alu_out = bus.operand_a - bus.operand_b;
            OpSlt:   alu_out = {{(WIDTH - 1){1'b0}},
                                $signed(bus.operand_a) < $signed(bus.operand_b)};
            OpNor:   alu_out = ~(bus.operand_a | bus.operand_b);
            default: alu_out = '0;
        endcase
    end

    // One partial product per cycle; only the low WIDTH bits of the product survive.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    if (bus.alu_control == OpMul) begin
                        mcand_d  = bus.operand_a;
                        mplier_d = bus.operand_b;
                        acc_d    = '0;
                        count_d  = CountInit;
                        state_d  = StMul;
                    end else begin
                        result_d = alu_out;
                        zero_d   = (alu_out == '0);
                        valid_d  = 1'b1;
                    end
                end
            end
            StMul: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CountOne;
                if (count_q == CountOne) begin
                    result_d = acc_sum;
                    zero_d   = (acc_sum == '0);
                    valid_d  = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.in_ready     = (state_q == StIdle);
    assign bus.result       = result_q;
    assign bus.zero         = zero_q;
    assign bus.result_valid = valid_q;
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code from the ALU control decoder and operands from the register-read stage.
- Registers every result.
- Single-cycle ops run at full throughput (one per cycle).
- MUL runs as an iterative radix-2 shift-add multiplier. While it runs, in_ready is low so the pipeline stalls.

Parameters:
WIDTH, 32, datapath width in bits; MUL iteration count equals WIDTH
SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  unit can accept an operation this cycle
alu_control  input  4  op code: 0 AND, 1 OR, 2 ADD, 3 SLL, 4 SRL, 5 SUB, 6 MUL, 7 SLT, 12 NOR
operand_a  input  WIDTH  rs value
operand_b  input  WIDTH  rt value / sign-extended immediate
shamt  input  SHAMT_W  shift amount for SLL/SRL
result  output  WIDTH  registered result
zero  output  1  registered flag, result == 0
result_valid  output  1  one-cycle pulse marking a new result

Behaviour:
- Clocking: one clock (clk). Reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: result=0, zero=1, result_valid=0, in_ready=1, state=IDLE, iteration counter=0, multiplier registers=0.
- Accept rule: an operation is accepted on an edge where in_valid && in_ready. Inputs are ignored when in_ready=0; the upstream stage must hold them.
- State machine: IDLE, MUL.
- IDLE:
  - in_ready=1.
  - Accepted non-MUL op: result and zero are written on the same edge. result_valid=1 for the following cycle. State stays IDLE, so back-to-back accepts give one result per cycle.
  - Accepted MUL: load multiplicand=operand_a, multiplier=operand_b, accumulator=0, counter=WIDTH. Go to MUL. result_valid=0 next cycle.
- MUL:
  - in_ready=0.
  - Each edge: if multiplier[0], accumulator += multiplicand (mod 2^WIDTH). Then multiplicand <<= 1, multiplier >>= 1, counter -= 1.
  - On the edge where counter goes 1→0: result=updated accumulator, zero updated, result_valid=1 next cycle, state=IDLE.
- MUL latency: accept at edge N → result_valid high in the cycle after edge N+WIDTH. in_ready is low during exactly WIDTH cycles.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH. No overflow trap or flag.
  - MUL returns the low WIDTH bits of the product. These are identical for signed and unsigned operands.
  - SLT: two's-complement signed compare, result = {WIDTH-1 zeros, (a<b)}.
  - SLL: operand_b << shamt. SRL: operand_b >> shamt, logical (zero fill). operand_a is unused for shifts.
  - NOR: ~(a|b).
  - Undefined codes (8–11, 13–15): result=0, zero=1, single-cycle, result_valid pulses normally.
- Output hold: result and zero hold their value until the next result write. result_valid is high for exactly one cycle per accepted op.
- No downstream backpressure: the consumer must take the result in the result_valid cycle.
- Reset mid-MUL: the multiply is abandoned and no result_valid is produced. Outputs take reset values on that edge. in_ready=1 in the next cycle.
- Reset has priority over an accept on the same edge; that op is dropped.
- in_valid held high through a MUL: the next op is accepted on the first edge where in_ready=1, i.e. in the same cycle that the MUL's result_valid is high.

Test Plan:
- Single-cycle ops back-to-back: ADD 7+5, SUB 3-5, AND 0xF0F0&0xFF00, OR 0x0F|0xF0, NOR 0|0, one op per cycle → result_valid high 5 consecutive cycles with 12, 0xFFFFFFFE, 0xF000, 0xFF, 0xFFFFFFFF; zero=0 throughout.
- SLT and shifts:
  - SLT a=0xFFFFFFFF, b=1 → result 1.
  - SLT a=1, b=0xFFFFFFFF → result 0, zero=1.
  - SLL b=1, shamt=31 → 0x80000000.
  - SRL b=0x80000000, shamt=31 → 1.
- MUL timing: MUL a=6, b=7 accepted at edge N → in_ready=0 for exactly 32 cycles; result=42 with result_valid in the cycle after edge N+32. MUL a=0xFFFFFFFF (−1), b=3 → 0xFFFFFFFD.
- Stall and queued op: MUL held, then ADD 1+1 presented with in_valid held high during the MUL → ADD is not accepted until in_ready=1. MUL result is seen, then result 2 the next cycle. Exactly two result_valid pulses.
- Reset mid-MUL: assert rst at iteration 10 of MUL 3×3 → no result_valid, result=0, zero=1, in_ready=1 next cycle. A subsequent ADD 2+2 returns 4.
- Wrap, zero, undefined: ADD 0xFFFFFFFF+1 → result 0, zero=1. Undefined code 9 → result 0, zero=1, one result_valid pulse.
